// File: rtl/dram_read_responder.sv
// Burst-read responder: queues read requests, then replays each burst from a
// preloadable 512-bit-wide memory as one beat per two 256-bit blocks.
module dram_read_responder #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5:0]                rd_id_in,
    input  logic [31:0]               rd_addr_in,
    input  logic [7:0]                rd_len_in,
    input  logic                      rd_info_valid_in,
    output logic                      rd_info_rdy_out,
    output logic [511:0]              rd_data_out,
    output logic [5:0]                rd_data_id_out,
    output logic                      rd_data_last_out,
    output logic                      rd_data_valid_out,
    input  logic                      rd_data_rdy_in,
    input  logic                      wr_en_in,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [511:0]              wr_data_in
);
    localparam int PW = $clog2(REQ_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t r_state, w_next_state;

    logic [5:0]                r_fifo_id    [REQ_FIFO_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] r_fifo_addr  [REQ_FIFO_DEPTH];
    logic [7:0]                r_fifo_beats [REQ_FIFO_DEPTH];
    logic [PW-1:0]             r_wptr, r_rptr;
    logic [PW:0]               r_count;
    logic                      r_full;
    logic                      w_push, w_pop, w_empty, w_fire;
    logic [7:0]                w_req_beats;

    logic [511:0]              r_mem [2**MEM_ADDR_WIDTH];
    logic [511:0]              r_rdata;

    logic [5:0]                r_id;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_beats;
    logic [511:0]              r_data;
    logic                      r_valid;
    logic                      w_unused;

    assign w_unused        = ^{rd_addr_in[31:MEM_ADDR_WIDTH+6], rd_addr_in[5:0]};
    assign w_empty         = (r_count == '0);
    // Ready comes only from the registered full flag, so a same-cycle pop never frees a slot.
    assign rd_info_rdy_out = ~r_full & ~rst;
    assign w_push          = rd_info_valid_in & rd_info_rdy_out;
    assign w_pop           = (r_state == IDLE) & ~w_empty;
    assign w_req_beats     = {1'b0, rd_len_in[7:1]} + {7'b0, rd_len_in[0]};
    assign w_fire          = r_valid & rd_data_rdy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_id[r_wptr]    <= rd_id_in;
                r_fifo_addr[r_wptr]  <= rd_addr_in[MEM_ADDR_WIDTH+5:6];
                r_fifo_beats[r_wptr] <= w_req_beats;
                r_wptr               <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + 1'b1;
                    r_full  <= (r_count == (PW+1)'(REQ_FIFO_DEPTH - 1));
                end
                2'b01: begin
                    r_count <= r_count - 1'b1;
                    r_full  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read-first memory; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            r_mem[wr_addr_in] <= wr_data_in;
        end
        if (r_state == LOAD) begin
            r_rdata <= r_mem[r_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_next_state = (r_fifo_beats[r_rptr] == 8'd0) ? IDLE : LOAD;
            LOAD:    w_next_state = SEND;
            SEND:    if (w_fire) w_next_state = (r_beats == 8'd1) ? IDLE : LOAD;
            default: w_next_state = IDLE;
        endcase
    end

    // First SEND cycle moves the memory word into the output register and raises valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_beats <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_id    <= r_fifo_id[r_rptr];
                        r_addr  <= r_fifo_addr[r_rptr];
                        r_beats <= r_fifo_beats[r_rptr];
                    end
                end
                SEND: begin
                    if (!r_valid) begin
                        r_data  <= r_rdata;
                        r_valid <= 1'b1;
                    end else if (rd_data_rdy_in) begin
                        r_valid <= 1'b0;
                        r_beats <= r_beats - 8'd1;
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data_out       = r_data;
    assign rd_data_id_out    = r_id;
    assign rd_data_valid_out = r_valid;
    assign rd_data_last_out  = r_valid & (r_beats == 8'd1);

endmodule

// File: tb/tb_dram_read_responder.sv
// Bench for dram_read_responder: directed scenarios plus randomized traffic,
// all beats checked against a queue-based model of the read responses.
`timescale 1ns/1ps
module tb_dram_read_responder;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int W     = 519;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   rd_id_in;
    logic [31:0]  rd_addr_in;
    logic [7:0]   rd_len_in;
    logic         rd_info_valid_in;
    logic         rd_info_rdy_out;
    logic [511:0] rd_data_out;
    logic [5:0]   rd_data_id_out;
    logic         rd_data_last_out;
    logic         rd_data_valid_out;
    logic         rd_data_rdy_in;
    logic         wr_en_in;
    logic [AW-1:0] wr_addr_in;
    logic [511:0] wr_data_in;

    dram_read_responder #(.MEM_ADDR_WIDTH(AW), .REQ_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rd_id_in(rd_id_in), .rd_addr_in(rd_addr_in), .rd_len_in(rd_len_in),
        .rd_info_valid_in(rd_info_valid_in), .rd_info_rdy_out(rd_info_rdy_out),
        .rd_data_out(rd_data_out), .rd_data_id_out(rd_data_id_out),
        .rd_data_last_out(rd_data_last_out), .rd_data_valid_out(rd_data_valid_out),
        .rd_data_rdy_in(rd_data_rdy_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_q = 1'b0;

    logic [511:0] model_mem [DEPTH];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] log_q [$];
    logic [W-1:0] cur, held;
    logic hold = 0, gap_pending = 0, prev_valid = 0;
    logic lat_arm = 0, lat_pending = 0;
    int hs_cyc = 0, acc_cyc = 0, lat_val = -1;
    logic done = 0;
    logic [5:0] t3_ids [7] = '{6'h30, 6'd1, 6'd1, 6'd3, 6'd3, 6'd4, 6'd5};

    task automatic check(input string name, input logic [527:0] act, input logic [527:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Model: every accepted request expands into ceil(len/2) beats read from
    // the model memory at acceptance time, with word addresses wrapping.
    always @(negedge clk) begin
        if (wr_en_in) model_mem[wr_addr_in] = wr_data_in;
        if (rst_q) begin
            check("rst_valid", rd_data_valid_out, 0);
            check("rst_last", rd_data_last_out, 0);
            check("rst_data", rd_data_out, 0);
            check("rst_id", rd_data_id_out, 0);
            check("rst_rdy", rd_info_rdy_out, !rst);
        end
        if (rst) begin
            exp_q.delete();
            hold = 0;
            gap_pending = 0;
            prev_valid = 0;
            lat_pending = 0;
        end else begin
            if (rd_data_valid_out) begin
                cur = {rd_data_last_out, rd_data_id_out, rd_data_out};
                if (!prev_valid && gap_pending) begin
                    check("beat_gap", cyc - hs_cyc, 2);
                    gap_pending = 0;
                end
                if (!prev_valid && lat_pending) begin
                    lat_val = cyc - acc_cyc;
                    lat_pending = 0;
                end
                if (hold) check("hold_stable", cur, held);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat act=%0h exp=none", cur);
                end else begin
                    check("beat", cur, exp_q[0]);
                    if (rd_data_rdy_in) begin
                        void'(exp_q.pop_front());
                        log_q.push_back(cur);
                        hs_cyc = cyc + 1;
                        gap_pending = !rd_data_last_out;
                        hold = 0;
                    end else begin
                        hold = 1;
                        held = cur;
                    end
                end
            end else begin
                if (hold) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_withdrawn act=valid0 exp=valid1");
                end
                hold = 0;
            end
            prev_valid = rd_data_valid_out;
            if (rd_info_valid_in && rd_info_rdy_out) begin
                int nb, start;
                nb = (int'(rd_len_in) + 1) / 2;
                start = int'(rd_addr_in[AW+5:6]);
                for (int k = 0; k < nb; k++) begin
                    exp_q.push_back({(k == nb - 1), rd_id_in, model_mem[(start + k) % DEPTH]});
                end
                acc_cyc = cyc + 1;
                if (lat_arm) begin
                    lat_pending = 1;
                    lat_arm = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic r;
        r = 0;
        rd_id_in = id;
        rd_addr_in = addr;
        rd_len_in = len;
        rd_info_valid_in = 1;
        for (int t = 0; t < 2000; t++) begin
            r = rd_info_rdy_out;
            tick();
            if (r) break;
        end
        rd_info_valid_in = 0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL req_timeout act=not_accepted exp=accepted");
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [511:0] d);
        wr_en_in = 1;
        wr_addr_in = a;
        wr_data_in = d;
        tick();
        wr_en_in = 0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            tick();
            if (exp_q.size() == 0 && !rd_data_valid_out) break;
        end
        if (t == budget) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout act=%0d_pending exp=0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic wait_valid(input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            if (rd_data_valid_out) break;
            tick();
        end
        if (t == budget) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout act=0 exp=1");
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [7:0] len;
        int t;
        rst = 1;
        rd_id_in = 0;
        rd_addr_in = 0;
        rd_len_in = 0;
        rd_info_valid_in = 0;
        rd_data_rdy_in = 1;
        wr_en_in = 0;
        wr_addr_in = 0;
        wr_data_in = 0;
        repeat (3) tick();
        rst = 0;
        tick();
        check("rdy_after_reset", rd_info_rdy_out, 1);

        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
            preload(AW'(i), d);
        end
        for (int i = 0; i < 4; i++) preload(AW'(i), 512'(8'hA0 + i));
        preload(AW'(DEPTH - 1), 512'hBEEF);
        preload(AW'(8), 512'h1111);

        // Single burst: words 1,2 returned, first beat 3 cycles after acceptance.
        log_q.delete();
        lat_arm = 1;
        lat_val = -1;
        send_req(6'd5, 32'h40, 8'd4);
        wait_idle(100);
        check("t1_nbeats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t1_beat0", log_q[0], {1'b0, 6'd5, 512'hA1});
            check("t1_beat1", log_q[1], {1'b1, 6'd5, 512'hA2});
        end
        check("t1_latency", lat_val, 3);

        // Backpressure on the first beat.
        rd_data_rdy_in = 0;
        log_q.delete();
        send_req(6'd5, 32'h40, 8'd4);
        wait_valid(50);
        repeat (5) tick();
        check("t2_held_data", rd_data_out, 512'hA1);
        check("t2_held_last", rd_data_last_out, 0);
        rd_data_rdy_in = 1;
        wait_idle(100);
        check("t2_nbeats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t2_beat0", log_q[0], {1'b0, 6'd5, 512'hA1});
            check("t2_beat1", log_q[1], {1'b1, 6'd5, 512'hA2});
        end

        // FIFO fill behind a stalled burst, with a zero-length request inside.
        rd_data_rdy_in = 0;
        log_q.delete();
        send_req(6'h30, 32'h80, 8'd2);
        wait_valid(50);
        send_req(6'd1, 32'h0, 8'd4);
        send_req(6'd2, 32'h40, 8'd0);
        send_req(6'd3, 32'hC0, 8'd3);
        send_req(6'd4, 32'h100, 8'd1);
        check("t3_rdy_full", rd_info_rdy_out, 0);
        repeat (2) tick();
        check("t3_rdy_still_full", rd_info_rdy_out, 0);
        rd_data_rdy_in = 1;
        send_req(6'd5, 32'h140, 8'd2);
        wait_idle(200);
        check("t3_nbeats", log_q.size(), 7);
        if (log_q.size() == 7) begin
            for (int i = 0; i < 7; i++) check("t3_id_order", log_q[i][517:512], t3_ids[i]);
        end

        // Wrap from the last word to word 0.
        log_q.delete();
        lat_arm = 1;
        lat_val = -1;
        send_req(6'd9, (DEPTH - 1) * 64, 8'd4);
        wait_idle(100);
        check("t4_nbeats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t4_beat0", log_q[0], {1'b0, 6'd9, 512'hBEEF});
            check("t4_beat1", log_q[1], {1'b1, 6'd9, 512'hA0});
        end
        check("t4_latency", lat_val, 3);

        // Reset during beat 2 of a 4-beat burst.
        log_q.delete();
        send_req(6'h11, 32'h100, 8'd8);
        for (t = 0; t < 100; t++) begin
            if (log_q.size() == 1 && rd_data_valid_out) break;
            tick();
        end
        check("t5_reached_beat2", log_q.size(), 1);
        rst = 1;
        tick();
        rst = 0;
        check("t5_valid_after_rst", rd_data_valid_out, 0);
        repeat (10) tick();
        check("t5_no_more_beats", log_q.size(), 1);
        send_req(6'h12, 32'h0, 8'd2);
        wait_idle(100);
        check("t5_nbeats", log_q.size(), 2);
        if (log_q.size() == 2) check("t5_mem_intact", log_q[1], {1'b1, 6'h12, 512'hA0});

        // Write to the word being read while the FSM is in LOAD.
        log_q.delete();
        send_req(6'd7, 32'd8 * 64, 8'd1);
        tick();
        wr_en_in = 1;
        wr_addr_in = AW'(8);
        wr_data_in = 512'h2222;
        tick();
        wr_en_in = 0;
        wait_idle(100);
        send_req(6'd7, 32'd8 * 64, 8'd1);
        wait_idle(100);
        check("t6_nbeats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t6_old_data", log_q[0], {1'b1, 6'd7, 512'h1111});
            check("t6_new_data", log_q[1], {1'b1, 6'd7, 512'h2222});
        end

        // Random traffic with random backpressure.
        done = 0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 12));
                    send_req(6'($urandom_range(0, 63)), $urandom, len);
                end
                wait_idle(5000);
                done = 1;
            end
            begin
                while (!done) begin
                    rd_data_rdy_in = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        rd_data_rdy_in = 1;
        check("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_read_responder.md
DRAM_READ_RESPONDER -- requirements
Module: dram_read_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MEM_ADDR_WIDTH, 10, log2 of backing-memory depth in 512-bit words.
- REQ_FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous, active-high reset.
- rd_id_in, in, 6, burst ID.
- rd_addr_in, in, 32, byte address; bits [5:0] ignored.
- rd_len_in, in, 8, burst length in 256-bit blocks.
- rd_info_valid_in, in, 1, request valid.
- rd_info_rdy_out, out, 1, request accepted when high together with valid.
- rd_data_out, out, 512, read data beat.
- rd_data_id_out, out, 6, ID of the burst owning the current beat.
- rd_data_last_out, out, 1, final beat of the burst.
- rd_data_valid_out, out, 1, beat valid.
- rd_data_rdy_in, in, 1, beat consumed when high together with valid.
- wr_en_in, in, 1, preload write strobe.
- wr_addr_in, in, MEM_ADDR_WIDTH, preload word address.
- wr_data_in, in, 512, preload data.

Function
REQ-003 Requests SHALL be pushed into a REQ_FIFO_DEPTH-entry FIFO on any clk edge where rd_info_valid_in and rd_info_rdy_out are both high.
REQ-004 rd_info_rdy_out SHALL equal NOT fifo_full, with fifo_full registered; a pop in the same cycle SHALL NOT make room for a push while full.
REQ-005 Backing memory SHALL be 2^MEM_ADDR_WIDTH x 512 bits with one-cycle synchronous read.
- Write SHALL occur on an edge with wr_en_in high.
- Read and write to the same word in the same cycle SHALL return the old data (read-first).
REQ-006 Start word address SHALL be rd_addr_in[MEM_ADDR_WIDTH+5:6].
- Word address SHALL increment by 1 per beat.
- Word address SHALL wrap modulo 2^MEM_ADDR_WIDTH.
REQ-007 Beat count SHALL be ceil(rd_len_in/2), computed in 8 bits: len=1 gives 1 beat, len=2 gives 1, len=3 gives 2, len=255 gives 128.
REQ-008 The FSM SHALL have three states: IDLE, LOAD, SEND.
REQ-009 IDLE behaviour:
- If the FIFO is non-empty, pop the head and latch its ID, word address and beat count.
- Next state SHALL be LOAD, or IDLE if beat count is 0 (len=0 requests are dropped with no beats).
- If the FIFO is empty, stay in IDLE.
REQ-010 LOAD SHALL issue a memory read at the current word address and go to SEND; on entry to SEND the read data SHALL be registered into rd_data_out with rd_data_valid_out high.
REQ-011 In SEND, rd_data_out, rd_data_id_out and rd_data_last_out SHALL hold stable while rd_data_valid_out is high and rd_data_rdy_in is low.
REQ-012 In SEND, on rd_data_valid_out and rd_data_rdy_in:
- Deassert rd_data_valid_out.
- Decrement the remaining-beat count.
- Go to IDLE if the beat was last, otherwise go to LOAD with the address incremented.
REQ-013 rd_data_last_out SHALL be high exactly when the remaining-beat count is 1 while valid.
REQ-014 Timing:
- The first beat SHALL become valid 3 clk cycles after the request-accepting edge when the FIFO was empty and the FSM was in IDLE.
- Subsequent beats SHALL become valid 2 cycles after the previous beat's handshake.
REQ-015 Bursts SHALL be returned strictly in acceptance order; beats of different bursts SHALL NOT interleave.
REQ-016 Preload writes SHALL be accepted in every state and SHALL NOT stall the FSM.

Reset
REQ-017 While rst is high, and on the edge after rst falls, all of the following SHALL hold:
- FIFO empty.
- FSM in IDLE.
- rd_info_rdy_out = 0 during rst and 1 after.
- rd_data_valid_out = 0, rd_data_last_out = 0.
- rd_data_out = 0, rd_data_id_out = 0.
REQ-018 Reset mid-burst SHALL discard all queued and in-flight requests with no further beats.
REQ-019 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-020 Single-burst test:
- Stimulus: preload words 0..3 with values 0xA0..0xA3; request id=5, addr=0x40, len=4; rdy held high.
- Response: 2 beats, 0xA1 then 0xA2; id=5 on both; last only on the second beat; first valid 3 cycles after acceptance.
REQ-021 Backpressure test:
- Stimulus: same as REQ-020, with rd_data_rdy_in low for 5 cycles on the first beat.
- Response: data, id and last held stable for 5 cycles; no beat lost or duplicated.
REQ-022 FIFO-full and zero-length test:
- Stimulus: 5 back-to-back requests with rdy_in low; the 2nd request has len=0.
- Response: rd_info_rdy_out drops after the 4th request is accepted.
- Response: the len=0 request produces no beats.
- Response: the remaining bursts return in order with correct IDs.
REQ-023 Wrap-around test:
- Stimulus: addr = (2^MEM_ADDR_WIDTH - 1) * 64, len=4.
- Response: beats from the last word then word 0.
REQ-024 Mid-burst reset test:
- Stimulus: assert rst for 1 cycle during beat 2 of a len=8 burst.
- Response: valid = 0 next cycle; no further beats; a new request after reset returns correct data, with preloaded memory intact.
REQ-025 Read-first test:
- Stimulus: write word N in the same cycle the FSM is in LOAD at word N.
- Response: the beat carries the old data; a following burst to word N returns the new data.
